// File: rtl/sysid_check_ctrl.sv
// Reads the sysid slave (ID at word 0, timestamp at word 1) and flags whether both match.
// Optional read timeout is enabled by defining SYSID_CHECK_TIMEOUT_EN.
module sysid_check_ctrl #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'd1487538347,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_ID  = 2'd1,
        RD_TS  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    logic   accept;
    logic   expired;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("sysid_check_ctrl: TIMEOUT_CYCLES must be in 1..65535");
    end

    assign accept = avm_read && !avm_waitrequest;

`ifdef SYSID_CHECK_TIMEOUT_EN
    logic [15:0] wait_cnt;

    // Threshold is reached by the stall in progress this cycle, so the read
    // is abandoned after exactly TIMEOUT_CYCLES stalled cycles.
    assign expired = avm_read && avm_waitrequest &&
                     (({1'b0, wait_cnt} + 17'd1) == 17'(TIMEOUT_CYCLES));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (avm_read && avm_waitrequest) begin
            wait_cnt <= wait_cnt + 16'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timeout <= 1'b0;
        end else if (state == IDLE && start) begin
            timeout <= 1'b0;
        end else if (expired) begin
            timeout <= 1'b1;
        end
    end
`else
    assign expired = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RD_ID;
            RD_ID:   if (accept) state_next = RD_TS;
                     else if (expired) state_next = FINISH;
            RD_TS:   if (accept || expired) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus strobes decode straight from state so an async reset drops them at once.
    always_comb begin
        avm_read    = 1'b0;
        avm_address = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            IDLE:   busy = 1'b0;
            RD_ID:  avm_read = 1'b1;
            RD_TS: begin
                avm_read    = 1'b1;
                avm_address = 1'b1;
            end
            FINISH: done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
        end else begin
            if (state == IDLE && start) begin
                id_ok <= 1'b0;
                ts_ok <= 1'b0;
            end
            if (state == RD_ID && accept) begin
                id_value <= avm_readdata;
                id_ok    <= (avm_readdata == EXPECTED_ID);
            end
            if (state == RD_TS && accept) begin
                ts_value <= avm_readdata;
                ts_ok    <= (avm_readdata == EXPECTED_TS);
            end
        end
    end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Scoreboard bench for sysid_check_ctrl: expected results queued at start, compared on done.
module tb_sysid_check_ctrl;

    localparam logic [31:0] EXP_ID     = 32'h0000_0000;
    localparam logic [31:0] EXP_TS     = 32'd1487538347;
    localparam int unsigned TB_TIMEOUT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    sysid_check_ctrl #(
        .EXPECTED_ID   (EXP_ID),
        .EXPECTED_TS   (EXP_TS),
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata   (avm_readdata),
        .busy           (busy),
        .done           (done),
        .id_ok          (id_ok),
        .ts_ok          (ts_ok),
        .timeout        (timeout),
        .id_value       (id_value),
        .ts_value       (ts_value)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] id_value;
        logic [31:0] ts_value;
        logic        id_ok;
        logic        ts_ok;
        logic        timeout;
        int unsigned done_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned done_count = 0;
    int unsigned addr_err = 0;
    logic [31:0] model_id = '0;
    logic [31:0] model_ts = '0;

    // Slave model
    logic [31:0] id_word = '0;
    logic [31:0] ts_word = '0;
    int unsigned wait_cycles = 0;
    logic        stuck_ts = 1'b0;
    int unsigned stall_cnt = 0;
    logic        prev_stalled = 1'b0;
    logic        prev_addr = 1'b0;

    assign avm_readdata    = avm_address ? ts_word : id_word;
    assign avm_waitrequest = avm_read && ((stuck_ts && avm_address) || (stall_cnt < wait_cycles));

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (avm_read && avm_waitrequest) stall_cnt <= stall_cnt + 1;
        else stall_cnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Address stability during stalls, and done-pulse scoreboard.
    always @(negedge clock) begin
        if (prev_stalled && avm_read && avm_address != prev_addr) addr_err <= addr_err + 1;
        prev_stalled <= avm_read && avm_waitrequest;
        prev_addr    <= avm_address;
        if (done) begin
            done_count <= done_count + 1;
            if (exp_q.size() == 0) begin
                check("done_unexpected", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_cycle", cyc, e.done_cyc);
                check("id_value", id_value, e.id_value);
                check("ts_value", ts_value, e.ts_value);
                check("flags", {29'd0, id_ok, ts_ok, timeout}, {29'd0, e.id_ok, e.ts_ok, e.timeout});
                check("busy_finish", 32'(busy), 32'd1);
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clock);
            #1;
        end
        check("seq_drained", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic hold_check(input string tag);
        repeat (3) @(negedge clock);
        #1;
        check({tag, "_id_hold"}, id_value, model_id);
        check({tag, "_ts_hold"}, ts_value, model_ts);
        check({tag, "_idle"}, {30'd0, busy, avm_read}, 32'd0);
    endtask

    task automatic queue_seq(input logic [31:0] idw, input logic [31:0] tsw,
                             input int unsigned w, input logic stuck);
        exp_t e;
        e.id_value = idw;
        e.id_ok    = (idw == EXP_ID);
        if (stuck) begin
            e.ts_value = model_ts;
            e.ts_ok    = 1'b0;
            e.timeout  = 1'b1;
            e.done_cyc = cyc + 2 + w + TB_TIMEOUT;
        end else begin
            e.ts_value = tsw;
            e.ts_ok    = (tsw == EXP_TS);
            e.timeout  = 1'b0;
            e.done_cyc = cyc + 3 + 2 * w;
        end
        model_id = e.id_value;
        model_ts = e.ts_value;
        exp_q.push_back(e);
    endtask

    task automatic run_seq(input logic [31:0] idw, input logic [31:0] tsw,
                           input int unsigned w, input logic stuck);
        id_word = idw; ts_word = tsw; wait_cycles = w; stuck_ts = stuck;
        @(negedge clock);
        queue_seq(idw, tsw, w, stuck);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_drain();
    endtask

    initial begin
        repeat (3) @(negedge clock);
        #1;
        check("rst_ctrl", {25'd0, avm_read, avm_address, busy, done, id_ok, ts_ok, timeout}, 32'd0);
        check("rst_id", id_value, 32'd0);
        check("rst_ts", ts_value, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Nominal zero-wait, wrong ID, long stalls, random-ish data
        run_seq(EXP_ID, EXP_TS, 0, 1'b0);
        hold_check("nominal");
        run_seq(32'h0000_0001, EXP_TS, 0, 1'b0);
        hold_check("bad_id");
        addr_err = 0;
        run_seq(EXP_ID, EXP_TS, 5, 1'b0);
        check("addr_stable", addr_err, 32'd0);
        run_seq($urandom, $urandom, 2, 1'b0);
        run_seq(EXP_ID, 32'hDEAD_BEEF, 1, 1'b0);
        hold_check("bad_ts");

`ifdef SYSID_CHECK_TIMEOUT_EN
        run_seq(EXP_ID, EXP_TS, 0, 1'b1);
        hold_check("timeout");
        run_seq(EXP_ID, EXP_TS, 3, 1'b1);
        run_seq(EXP_ID, EXP_TS, 0, 1'b0);
`endif

        // Reset during the timestamp read
        id_word = EXP_ID; ts_word = EXP_TS; wait_cycles = 3; stuck_ts = 1'b0;
        @(negedge clock);
        queue_seq(EXP_ID, EXP_TS, 3, 1'b0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (avm_read && avm_address) break;
            @(negedge clock);
        end
        check("reach_rd_ts", {30'd0, avm_read, avm_address}, 32'd3);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_ctrl", {25'd0, avm_read, avm_address, busy, done, id_ok, ts_ok, timeout}, 32'd0);
        check("rst_mid_id", id_value, 32'd0);
        exp_q.delete();
        model_id = '0;
        model_ts = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        hold_check("post_rst");
        run_seq(EXP_ID, EXP_TS, 0, 1'b0);

        // Start while busy and on the done cycle: one sequence only
        begin
            int unsigned dc;
            dc = done_count;
            wait_cycles = 0;
            @(negedge clock);
            queue_seq(EXP_ID, EXP_TS, 0, 1'b0);
            start = 1'b1;
            @(negedge clock);
            @(negedge clock);
            start = 1'b0;
            @(negedge clock);
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            repeat (6) @(negedge clock);
            #1;
            check("one_done", done_count - dc, 32'd1);
            check("busy_after", 32'(busy), 32'd0);
            wait_drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
